// File: rtl/mdc32_fft_sequencer.sv
// mdc32_fft_sequencer: frame sequencer for the 32-point radix-2 MDC FFT; define BITREV_IDX_EN to add bit-reversed bin index outputs
module mdc32_fft_sequencer #(
  parameter int BF_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_sop,
  output logic        in_ready,
  output logic        dp_en,
  output logic        in_mode,
  output logic [3:0]  sw_sel,
  output logic [15:0] twid_addr,
  output logic        out_valid,
  output logic [3:0]  out_idx,
  output logic        frame_done,
  output logic        busy
`ifdef BITREV_IDX_EN
  ,
  output logic [4:0]  out_k_up,
  output logic [4:0]  out_k_lo
`endif
);
  localparam int N = 32;
  localparam int LAT = 16 + 15 + 5 * BF_LAT;
  localparam int LAST = LAT + 15;
  localparam int TW = $clog2(LAST + 2);
  function automatic int stage_off(input int s);
    int o;
    o = 16 + (s + 1) * BF_LAT;
    for (int j = 0; j < s; j++) o += 1 << (3 - j);
    return o;
  endfunction
  localparam int OFF [4] = '{stage_off(0), stage_off(1), stage_off(2), stage_off(3)};
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;
  state_t state, nstate;
  logic [TW-1:0] t, tc, nt;
  logic acc, adv, done_pend;
  logic in_mode_n, ov_n;
  logic [3:0] sw_n, idx_n, d;
  logic [15:0] tw_n;
  // next count/state and the control word for the count being moved this cycle
  always_comb begin
    acc = in_valid && in_ready;
    tc = (state != DRAIN && acc && in_sop) ? '0 : t;
    adv = state == DRAIN || (acc && (state == LOAD || in_sop));
    nstate = state == IDLE ? (adv ? LOAD : IDLE)
           : state == LOAD ? ((adv && tc == TW'(N - 1)) ? DRAIN : LOAD)
           : (tc == TW'(LAST) ? IDLE : DRAIN);
    nt = (state == DRAIN && tc == TW'(LAST)) ? '0 : adv ? tc + 1'b1 : t;
    in_mode_n = tc < TW'(N) ? tc[4] : 1'b1;
    ov_n = tc >= TW'(LAT) && tc <= TW'(LAST);
    idx_n = ov_n ? 4'(tc - TW'(LAT)) : 4'd0;
    sw_n = '0;
    tw_n = '0;
    d = '0;
    for (int s = 0; s < 4; s++) begin
      d = 4'(tc - TW'(OFF[s]));
      sw_n[s] = (tc >= TW'(OFF[s]) && tc < TW'(OFF[s] + 16)) ? d[3-s] : 1'b0;
      tw_n[4*s +: 4] = (tc >= TW'(OFF[s]) && tc < TW'(OFF[s] + 16)) ? (d & (4'hF >> s)) << s : 4'd0;
    end
  end
  // FSM and registered outputs; a LOAD stall holds every control
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      t <= '0;
      done_pend <= 1'b0;
      in_ready <= 1'b0;
      dp_en <= 1'b0;
      in_mode <= 1'b0;
      sw_sel <= '0;
      twid_addr <= '0;
      out_valid <= 1'b0;
      out_idx <= '0;
      frame_done <= 1'b0;
      busy <= 1'b0;
`ifdef BITREV_IDX_EN
      out_k_up <= '0;
      out_k_lo <= '0;
`endif
    end else begin
      state <= nstate;
      t <= nt;
      done_pend <= state == DRAIN && tc == TW'(LAST);
      frame_done <= done_pend;
      in_ready <= nstate != DRAIN;
      dp_en <= adv;
      busy <= adv || nstate != IDLE;
      if (adv || state == IDLE) begin
        in_mode <= in_mode_n;
        sw_sel <= sw_n;
        twid_addr <= tw_n;
        out_valid <= ov_n;
        out_idx <= idx_n;
`ifdef BITREV_IDX_EN
        out_k_up <= ov_n ? {1'b0, idx_n[0], idx_n[1], idx_n[2], idx_n[3]} : 5'd0;
        out_k_lo <= ov_n ? {1'b1, idx_n[0], idx_n[1], idx_n[2], idx_n[3]} : 5'd0;
`endif
      end
    end
  end
endmodule

// File: tb/tb_mdc32_fft_sequencer.sv
// tb_mdc32_fft_sequencer: directed checks of the MDC32 FFT frame sequencer
module tb_mdc32_fft_sequencer;
  logic clk = 1'b0;
  logic rst, in_valid, in_sop;
  logic in_ready, dp_en, in_mode, out_valid, frame_done, busy;
  logic [3:0] sw_sel, out_idx;
  logic [15:0] twid_addr;
`ifdef BITREV_IDX_EN
  logic [4:0] out_k_up, out_k_lo;
`endif
  int tests = 0;
  int fails = 0;
  int fd_cnt, fd_at;

  mdc32_fft_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop),
    .in_ready(in_ready), .dp_en(dp_en), .in_mode(in_mode), .sw_sel(sw_sel),
    .twid_addr(twid_addr), .out_valid(out_valid), .out_idx(out_idx),
    .frame_done(frame_done), .busy(busy)
`ifdef BITREV_IDX_EN
    , .out_k_up(out_k_up), .out_k_lo(out_k_lo)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // hand-computed control word at frame count t (clean frame)
  task automatic check_t(input int t);
    case (t)
      0:  begin chk("t0_mode", in_mode, 0); chk("t0_ov", out_valid, 0); chk("t0_busy", busy, 1); end
      15: chk("t15_mode", in_mode, 0);
      16: chk("t16_mode", in_mode, 1);
      24: begin chk("t24_sw", sw_sel, 4'h0); chk("t24_tw", twid_addr, 16'h0007); end
      25: begin chk("t25_sw", sw_sel, 4'h1); chk("t25_tw", twid_addr, 16'h0008); end
      30: begin chk("t30_sw", sw_sel, 4'h3); chk("t30_tw", twid_addr, 16'h008D); chk("t30_rdy", in_ready, 1); end
      31: chk("t31_rdy", in_ready, 0);
      32: begin chk("t32_sw", sw_sel, 4'h3); chk("t32_tw", twid_addr, 16'h04CF); chk("t32_mode", in_mode, 1); end
      34: begin chk("t34_sw", sw_sel, 4'h4); chk("t34_tw", twid_addr, 16'h0C00); end
      35: begin chk("t35_sw", sw_sel, 4'h8); chk("t35_tw", twid_addr, 16'h8020); chk("t35_ov", out_valid, 0); end
      36: begin chk("t36_ov", out_valid, 1); chk("t36_idx", out_idx, 0); end
      37: begin
        chk("t37_idx", out_idx, 1);
`ifdef BITREV_IDX_EN
        chk("t37_kup", out_k_up, 8); chk("t37_klo", out_k_lo, 24);
`endif
      end
      49: begin chk("t49_sw", sw_sel, 4'h8); chk("t49_tw", twid_addr, 16'h8000); end
      50: begin chk("t50_sw", sw_sel, 4'h0); chk("t50_tw", twid_addr, 16'h0000); end
      51: begin
        chk("t51_ov", out_valid, 1); chk("t51_idx", out_idx, 15); chk("t51_fd", frame_done, 0);
`ifdef BITREV_IDX_EN
        chk("t51_kup", out_k_up, 15); chk("t51_klo", out_k_lo, 31);
`endif
      end
      52: begin
        chk("t52_fd", frame_done, 1); chk("t52_ov", out_valid, 0); chk("t52_dp", dp_en, 0);
        chk("t52_busy", busy, 0); chk("t52_idx", out_idx, 0);
      end
      53: chk("t53_fd", frame_done, 0);
      default: ;
    endcase
  endtask

  initial begin
    // reset with stream active
    rst = 1; in_valid = 1; in_sop = 0;
    step(); step();
    chk("rst_ready", in_ready, 0); chk("rst_dp", dp_en, 0); chk("rst_busy", busy, 0);
    chk("rst_ov", out_valid, 0); chk("rst_tw", twid_addr, 0); chk("rst_sw", sw_sel, 0);
    rst = 0; in_valid = 0;
    step();
    chk("post_rst_ready", in_ready, 1); chk("post_rst_dp", dp_en, 0);
    // clean frame
    in_valid = 1; in_sop = 1;
    for (int c = 0; c <= 53; c++) begin
      step();
      in_sop = 0;
      if (c == 31) in_valid = 0;
      if (c <= 51) chk("clean_dp", dp_en, 1);
      check_t(c);
    end
    // stray samples without sop
    in_valid = 1; in_sop = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("stray_dp", dp_en, 0); chk("stray_busy", busy, 0);
    end
    in_valid = 0;
    step();
    // frame with a 3-cycle stall at t=10
    in_valid = 1; in_sop = 1;
    for (int c = 0; c <= 56; c++) begin
      step();
      in_sop = 0;
      in_valid = (c + 1 < 10 || c + 1 > 12) && c + 1 <= 34;
      if (c >= 10 && c <= 12) begin chk("stall_dp", dp_en, 0); chk("stall_rdy", in_ready, 1); end
      if (c == 11) begin chk("stall_mode", in_mode, 0); chk("stall_sw", sw_sel, 0); end
      if (c == 13) chk("stall_resume_dp", dp_en, 1);
      if (c == 38) chk("stall_ov_pre", out_valid, 0);
      if (c == 39) begin chk("stall_ov", out_valid, 1); chk("stall_idx", out_idx, 0); end
      if (c == 54) chk("stall_fd_pre", frame_done, 0);
      if (c == 55) chk("stall_fd", frame_done, 1);
    end
    // restart: sop again at t=20
    fd_cnt = 0; fd_at = -1;
    in_valid = 1; in_sop = 1;
    for (int c = 0; c <= 90; c++) begin
      step();
      in_sop = (c + 1 == 20);
      in_valid = c + 1 <= 51;
      if (frame_done) begin fd_cnt++; fd_at = c; end
      if (c == 19) chk("rs_mode_pre", in_mode, 1);
      if (c == 20) begin chk("rs_mode", in_mode, 0); chk("rs_dp", dp_en, 1); end
    end
    chk("rs_fd_cnt", fd_cnt, 1);
    chk("rs_fd_at", fd_at, 72);
    // reset in the middle of drain
    in_valid = 1; in_sop = 1;
    for (int c = 0; c < 40; c++) begin
      step();
      in_sop = 0;
      if (c == 31) in_valid = 0;
    end
    rst = 1;
    step();
    chk("mrst_dp", dp_en, 0); chk("mrst_ov", out_valid, 0); chk("mrst_busy", busy, 0); chk("mrst_rdy", in_ready, 0);
    rst = 0;
    fd_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (frame_done) fd_cnt++;
    end
    chk("mrst_fd_cnt", fd_cnt, 0);
    chk("mrst_busy_after", busy, 0);
    chk("mrst_rdy_after", in_ready, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
